cmat_mac_sequencer: RTL



---
 rtl/cmat_mac_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cmat_mac_sequencer.sv
// cmat_mac_sequencer
//   Address and control sequencer for the complex matrix multiply-accumulate
//   datapath computing C = A*B (DIM x DIM complex).  Walks operand memories in
//   row-major order (i outer, k middle, j inner), emits registered real/imag
//   addresses for A and B, and drives accumulator enable/clear through a
//   LAT-deep tag pipeline that tracks the memory/multiplier latency.
// Ports
//   clk_ctrl, rst_ctrl     : clock, asynchronous active-high reset
//   start                  : begin a multiply (sampled only in IDLE)
//   pause                  : freeze sequencer and datapath while high
//   busy, done             : run in progress / one-cycle completion pulse
//   ce_dp                  : datapath clock enable (~pause)
//   addr_valid, addr_*     : live term flag and A/B real/imag addresses
//   acc_en, acc_clr        : accumulate product / load product (first term)
//   res_valid, res_idx     : finished C element pulse and its row-major index
module cmat_mac_sequencer #(
  parameter int unsigned DIM = 3,
  parameter int unsigned LAT = 2,
  localparam int unsigned ADDR_W = $clog2(2 * DIM * DIM),
  localparam int unsigned IDX_W  = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1
) (
  input  logic              clk_ctrl,
  input  logic              rst_ctrl,
  input  logic              start,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              ce_dp,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr_a_re,
  output logic [ADDR_W-1:0] addr_a_im,
  output logic [ADDR_W-1:0] addr_b_re,
  output logic [ADDR_W-1:0] addr_b_im,
  output logic              acc_en,
  output logic              acc_clr,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx
);

  localparam int unsigned CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] CMAX     = CNT_W'(DIM - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM * DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic             v;
    logic             first;
    logic             last;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t state_q, state_d;
  logic   adv, load_first, step, last_term;

  logic [CNT_W-1:0] i_q, k_q, j_q;
  logic [CNT_W-1:0] ti, tk, tj;
  logic [ADDR_W-1:0] a_base, b_base;

  // s0_q travels with the address registers; dl_q[LAT-1] lines up with the
  // product arriving at the accumulator.
  tag_t s0_q;
  tag_t dl_q [LAT];
  tag_t dl_out;
  logic res_q;

  assign last_term = (i_q == CMAX) && (k_q == CMAX) && (j_q == CMAX);
  assign dl_out    = dl_q[LAT-1];

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    load_first = 1'b0;
    step       = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_first = start;
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        step = !pause;
        if (!pause && last_term) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (res_valid && res_idx == IDX_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pause only freezes things while a run is in flight.
  assign adv = !(pause && busy);

  // Next term: fresh (0,0,0) on start, otherwise j -> k -> i ripple.
  always_comb begin
    tj = j_q + CNT_W'(1);
    tk = k_q;
    ti = i_q;
    if (j_q == CMAX) begin
      tj = '0;
      tk = k_q + CNT_W'(1);
      if (k_q == CMAX) begin
        tk = '0;
        ti = i_q + CNT_W'(1);
      end
    end
    if (load_first) begin
      ti = '0;
      tk = '0;
      tj = '0;
    end
  end

  assign a_base = ADDR_W'(2 * (ti * DIM + tj));
  assign b_base = ADDR_W'(2 * (tj * DIM + tk));

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      i_q       <= '0;
      k_q       <= '0;
      j_q       <= '0;
      addr_a_re <= '0;
      addr_a_im <= '0;
      addr_b_re <= '0;
      addr_b_im <= '0;
      s0_q      <= '0;
      for (int unsigned n = 0; n < LAT; n++) dl_q[n] <= '0;
      res_q     <= 1'b0;
      res_idx   <= '0;
    end else begin
      if (load_first || (step && !last_term)) begin
        i_q       <= ti;
        k_q       <= tk;
        j_q       <= tj;
        addr_a_re <= a_base;
        addr_a_im <= a_base + ADDR_W'(1);
        addr_b_re <= b_base;
        addr_b_im <= b_base + ADDR_W'(1);
        s0_q.v     <= 1'b1;
        s0_q.first <= (tj == '0);
        s0_q.last  <= (tj == CMAX);
        s0_q.idx   <= IDX_W'(ti * DIM + tk);
      end else if (adv) begin
        s0_q <= '0;
      end
      if (adv) begin
        dl_q[0] <= s0_q;
        for (int unsigned n = 1; n < LAT; n++) dl_q[n] <= dl_q[n-1];
        res_q <= dl_out.v && dl_out.last;
        if (dl_out.v && dl_out.last) res_idx <= dl_out.idx;
      end
    end
  end

  assign ce_dp      = !pause;
  assign addr_valid = s0_q.v && adv;
  assign acc_en     = dl_out.v && adv;
  assign acc_clr    = dl_out.v && dl_out.first && adv;
  assign res_valid  = res_q && adv;

endmodule
